// File: rtl/i2c_master_if.sv
// Command, byte-stream and open-drain pin bundle between the I2C master and its user.
// The master modport is the controller's view; slave is the user/bench view.
interface i2c_master_if;
  logic       START;
  logic [6:0] ADDR;
  logic       RW;
  logic [7:0] NBYTES;
  logic [7:0] IDATA;
  logic       IREQ;
  logic [7:0] ODATA;
  logic       DRDY;
  logic       BUSY;
  logic       NACK;
  logic       SCL_OE;
  logic       SDA_OE;
  logic       SDA_I;

  modport master (
    input  START, ADDR, RW, NBYTES, IDATA, SDA_I,
    output IREQ, ODATA, DRDY, BUSY, NACK, SCL_OE, SDA_OE
  );

  modport slave (
    output START, ADDR, RW, NBYTES, IDATA, SDA_I,
    input  IREQ, ODATA, DRDY, BUSY, NACK, SCL_OE, SDA_OE
  );
endinterface

// File: rtl/i2c_master.sv
// Bit-banged I2C master: one command runs START, address, NBYTES data bytes and STOP.
// Every bit is four QDIV-cycle quarters; SCL is held low in Q0-Q1 and released in Q2-Q3.
module i2c_master #(
  parameter int unsigned QDIV = 25
) (
  input  logic        CLK,
  input  logic        NRST,
  i2c_master_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, STRT, ABIT, AACK, WBIT, WACK, RBIT, RACK, STOP
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] qcnt_q, qcnt_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  odata_q, odata_d;
  logic        rw_q, rw_d;
  logic        samp_q, samp_d;
  logic        nack_q, nack_d;
  logic        drdy_q, drdy_d;

  logic tick, bit_end, first_w;

  assign tick    = (qcnt_q == 16'(QDIV - 1));
  assign bit_end = tick && (qtr_q == 2'd3);
  // First cycle of a write byte: IDATA is consumed and drives SDA directly until it lands in shift_q
  assign first_w = (state_q == WBIT) && (bcnt_q == 3'd0) && (qtr_q == 2'd0) && (qcnt_q == 16'd0);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q <= IDLE;
      qcnt_q  <= '0;
      qtr_q   <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      odata_q <= '0;
      rw_q    <= 1'b0;
      samp_q  <= 1'b1;
      nack_q  <= 1'b0;
      drdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      qtr_q   <= qtr_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      odata_q <= odata_d;
      rw_q    <= rw_d;
      samp_q  <= samp_d;
      nack_q  <= nack_d;
      drdy_q  <= drdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    qtr_d   = qtr_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    odata_d = odata_q;
    rw_d    = rw_q;
    samp_d  = samp_q;
    nack_d  = nack_q;
    drdy_d  = 1'b0;

    if (state_q == IDLE) begin
      qcnt_d = '0;
      qtr_d  = '0;
      if (bus.START) begin
        state_d = STRT;
        shift_d = {bus.ADDR, bus.RW};
        rw_d    = bus.RW;
        cnt_d   = bus.NBYTES;
        nack_d  = 1'b0;
        bcnt_d  = '0;
      end
    end else begin
      qcnt_d = tick ? 16'd0 : qcnt_q + 16'd1;
      if (tick) qtr_d = qtr_q + 2'd1;
      if (first_w) shift_d = bus.IDATA;

      if (tick && qtr_q == 2'd2) begin
        samp_d = bus.SDA_I;
        if (state_q == RBIT) begin
          shift_d = {shift_q[6:0], bus.SDA_I};
          if (bcnt_q == 3'd7) begin
            odata_d = {shift_q[6:0], bus.SDA_I};
            drdy_d  = 1'b1;
          end
        end
      end

      if (bit_end) begin
        case (state_q)
          STRT: begin
            state_d = ABIT;
            bcnt_d  = '0;
          end
          ABIT, WBIT: begin
            shift_d = {shift_q[6:0], 1'b0};
            bcnt_d  = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = (state_q == ABIT) ? AACK : WACK;
          end
          AACK: begin
            if (samp_q) begin
              nack_d  = 1'b1;
              state_d = STOP;
            end else if (cnt_q == 8'd0) state_d = STOP;
            else state_d = rw_q ? RBIT : WBIT;
          end
          WACK: begin
            if (samp_q) begin
              nack_d  = 1'b1;
              state_d = STOP;
            end else begin
              cnt_d   = cnt_q - 8'd1;
              state_d = (cnt_q == 8'd1) ? STOP : WBIT;
            end
          end
          RBIT: begin
            bcnt_d = bcnt_q + 3'd1;
            if (bcnt_q == 3'd7) state_d = RACK;
          end
          RACK: begin
            cnt_d   = cnt_q - 8'd1;
            state_d = (cnt_q == 8'd1) ? STOP : RBIT;
          end
          STOP:    state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Line drive decoded from registered state so reset releases both lines immediately
  always_comb begin
    bus.SCL_OE = 1'b0;
    bus.SDA_OE = 1'b0;
    case (state_q)
      STRT: bus.SDA_OE = qtr_q[1];
      ABIT: begin
        bus.SCL_OE = ~qtr_q[1];
        bus.SDA_OE = ~shift_q[7];
      end
      WBIT: begin
        bus.SCL_OE = ~qtr_q[1];
        bus.SDA_OE = first_w ? ~bus.IDATA[7] : ~shift_q[7];
      end
      AACK, WACK, RBIT: bus.SCL_OE = ~qtr_q[1];
      RACK: begin
        bus.SCL_OE = ~qtr_q[1];
        bus.SDA_OE = (cnt_q > 8'd1);
      end
      STOP: begin
        bus.SCL_OE = ~qtr_q[1];
        bus.SDA_OE = (qtr_q != 2'd3);
      end
      default: ;
    endcase
  end

  assign bus.IREQ  = first_w;
  assign bus.BUSY  = (state_q != IDLE);
  assign bus.NACK  = nack_q;
  assign bus.DRDY  = drdy_q;
  assign bus.ODATA = odata_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: an I2C responder model on the wires plus a scoreboard of
// expected address/data/ack bits and read bytes, checked as the bus produces them.
module tb_i2c_master;
  localparam int QDIV = 4;
  localparam int BITC = 4 * QDIV;

  logic CLK, NRST;
  i2c_master_if bus();

  i2c_master #(.QDIV(QDIV)) dut (.CLK(CLK), .NRST(NRST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk, n_fail;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // responder configuration
  logic       cfg_rw, cfg_ack_addr;
  int         cfg_n, cfg_nack_at;
  logic [7:0] rbuf [4];
  logic [7:0] wbuf [8];

  // scoreboard
  logic [7:0] exp_byte [$];
  logic       exp_ack  [$];
  logic [7:0] exp_rd   [$];

  // monitor / responder state
  int         bitn, n_ireq, n_drdy, n_busy;
  logic [7:0] sh;
  logic       pull, pend, scl_p, sda_p;
  logic [2:0] widx;

  wire scl = ~bus.SCL_OE;
  wire sda = ~bus.SDA_OE & ~pull;
  assign bus.SDA_I = sda;
  assign bus.IDATA = wbuf[widx];

  function automatic logic resp(input int b);
    int by, w;
    by = b / 9;
    w  = b % 9;
    if (by == 0) return (w == 8) && cfg_ack_addr;
    if (by > cfg_n) return 1'b0;
    if (cfg_rw) return (w < 8) && !rbuf[by-1][7-w];
    return (w == 8) && (by != cfg_nack_at);
  endfunction

  initial begin
    bitn = 0; sh = '0; pull = 1'b0; pend = 1'b0; widx = '0;
    n_ireq = 0; n_drdy = 0; n_busy = 0; scl_p = 1'b1; sda_p = 1'b1;
    forever begin
      @(negedge CLK);
      if (!NRST) begin
        bitn = 0; pull = 1'b0; pend = 1'b0; widx = '0;
      end else begin
        if (pend) begin widx = widx + 3'd1; pend = 1'b0; end
        if (bus.START && !bus.BUSY) widx = '0;
        if (bus.IREQ) begin pend = 1'b1; n_ireq++; end
        if (bus.BUSY) n_busy++;
        if (bus.DRDY) begin
          n_drdy++;
          if (exp_rd.size() > 0) chk("odata", int'(bus.ODATA), int'(exp_rd.pop_front()));
          else chk("drdy_extra", 1, 0);
        end
        if (scl && scl_p && sda_p && !sda) bitn = 0;
        if (scl && !scl_p) begin
          if (bitn % 9 < 8) sh = {sh[6:0], sda};
          else if (exp_byte.size() > 0) begin
            chk("sda_byte", int'(sh), int'(exp_byte.pop_front()));
            chk("sda_ack", int'(sda), int'(exp_ack.pop_front()));
          end else chk("sda_byte_extra", int'(sh), -1);
          bitn++;
        end
        if (!scl && scl_p) pull = resp(bitn);
      end
      scl_p = scl;
      sda_p = sda;
    end
  end

  task automatic push(input logic [7:0] b, input logic a);
    exp_byte.push_back(b);
    exp_ack.push_back(a);
  endtask

  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] n);
    @(posedge CLK); #1;
    bus.START = 1'b1; bus.ADDR = a; bus.RW = r; bus.NBYTES = n;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    chk("busy_on", int'(bus.BUSY), 1);
    chk("nack_clr", int'(bus.NACK), 0);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 20000 && bus.BUSY; i++) @(negedge CLK);
    if (bus.BUSY) chk("idle_timeout", 1, 0);
  endtask

  // full transaction: bits = STRT + address/ack + data/ack + STOP actually run
  task automatic txn(input logic [6:0] a, input logic r, input logic [7:0] n,
                     input int bits, input int ireqs, input int drdys, input int nk);
    int s_i, s_d, s_b;
    s_i = n_ireq; s_d = n_drdy; s_b = n_busy;
    issue(a, r, n);
    wait_idle();
    @(negedge CLK);
    chk("busy_cycles", n_busy - s_b, bits * BITC);
    chk("ireq_count", n_ireq - s_i, ireqs);
    chk("drdy_count", n_drdy - s_d, drdys);
    chk("nack", int'(bus.NACK), nk);
    chk("sb_bytes_left", exp_byte.size(), 0);
    chk("sb_rd_left", exp_rd.size(), 0);
    chk("lines_idle", int'({bus.SCL_OE, bus.SDA_OE}), 0);
  endtask

  initial begin
    int i, s_i;
    n_chk = 0; n_fail = 0;
    NRST = 1'b0;
    bus.START = 1'b0; bus.ADDR = '0; bus.RW = 1'b0; bus.NBYTES = '0;
    cfg_rw = 1'b0; cfg_ack_addr = 1'b1; cfg_n = 0; cfg_nack_at = 0;
    for (i = 0; i < 4; i++) rbuf[i] = '0;
    for (i = 0; i < 8; i++) wbuf[i] = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_scl", int'(bus.SCL_OE), 0);
    chk("rst_sda", int'(bus.SDA_OE), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_ireq_drdy", int'({bus.IREQ, bus.DRDY}), 0);
    chk("rst_nack", int'(bus.NACK), 0);
    chk("rst_odata", int'(bus.ODATA), 0);
    NRST = 1'b1;

    // write two bytes, responder acks everything
    cfg_rw = 1'b0; cfg_n = 2; cfg_nack_at = 0; cfg_ack_addr = 1'b1;
    wbuf[0] = 8'hDE; wbuf[1] = 8'hAD; wbuf[2] = 8'h00;
    push(8'hAA, 1'b0); push(8'hDE, 1'b0); push(8'hAD, 1'b0);
    txn(7'h55, 1'b0, 8'd2, 1 + 9 + 18 + 1, 2, 0, 0);

    // read two bytes; master ACKs the first and NACKs the last
    cfg_rw = 1'b1; cfg_n = 2; rbuf[0] = 8'hA5; rbuf[1] = 8'h5A;
    push(8'hAB, 1'b0); push(8'hA5, 1'b0); push(8'h5A, 1'b1);
    exp_rd.push_back(8'hA5); exp_rd.push_back(8'h5A);
    txn(7'h55, 1'b1, 8'd2, 1 + 9 + 18 + 1, 0, 2, 0);
    chk("odata_hold", int'(bus.ODATA), 8'h5A);

    // silent responder: address NACK truncates to STRT + address + STOP
    cfg_rw = 1'b0; cfg_n = 3; cfg_ack_addr = 1'b0;
    push(8'h44, 1'b1);
    txn(7'h22, 1'b0, 8'd3, 1 + 9 + 1, 0, 0, 1);

    // address-only probe; its START must clear the sticky NACK
    cfg_ack_addr = 1'b1; cfg_n = 0;
    push(8'h78, 1'b0);
    txn(7'h3C, 1'b0, 8'd0, 1 + 9 + 1, 0, 0, 0);

    // data NACK on the second of three write bytes
    cfg_n = 3; cfg_nack_at = 2;
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    push(8'hAA, 1'b0); push(8'h11, 1'b0); push(8'h22, 1'b1);
    txn(7'h55, 1'b0, 8'd3, 1 + 9 + 18 + 1, 2, 0, 1);

    // ignored START mid-transfer, then reset inside a write byte
    cfg_n = 2; cfg_nack_at = 0;
    wbuf[0] = 8'hDE; wbuf[1] = 8'hAD;
    push(8'hAA, 1'b0);
    s_i = n_ireq;
    issue(7'h55, 1'b0, 8'd2);
    repeat (20) @(posedge CLK);
    #1;
    bus.START = 1'b1; bus.ADDR = 7'h11; bus.RW = 1'b1; bus.NBYTES = 8'd0;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    chk("busy_ign_start", int'(bus.BUSY), 1);
    for (i = 0; i < 2000 && bitn < 12; i++) @(negedge CLK);
    for (i = 0; i < 100 && scl; i++) @(negedge CLK);
    chk("reached_wbit3", int'(bitn == 12 && !scl), 1);
    chk("ireq_before_rst", n_ireq - s_i, 1);
    chk("sb_addr_done", exp_byte.size(), 0);
    NRST = 1'b0;
    #1;
    chk("mid_rst_scl", int'(bus.SCL_OE), 0);
    chk("mid_rst_sda", int'(bus.SDA_OE), 0);
    chk("mid_rst_busy", int'(bus.BUSY), 0);
    chk("mid_rst_odata", int'(bus.ODATA), 0);
    exp_byte.delete(); exp_ack.delete(); exp_rd.delete();
    @(posedge CLK); #1;
    NRST = 1'b1;
    repeat (2) @(posedge CLK);

    cfg_n = 1;
    wbuf[0] = 8'h3C;
    push(8'hAA, 1'b0); push(8'h3C, 1'b0);
    txn(7'h55, 1'b0, 8'd1, 1 + 9 + 9 + 1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
